c3lib_pipe_set_stall: RTL and testbench
=======================================

C3LIB_PIPE_SET_STALL -- requirements
Module: c3lib_pipe_set_stall

Interface
REQ-001 The module SHALL have parameter WIDTH, default 1, data width in bits (>=1).
REQ-002 The module SHALL have parameter DEPTH, default 2, number of register stages (>=1).
REQ-003 The module SHALL have parameter RST_VAL, WIDTH bits, default all ones; this is the value loaded into every data register on reset or flush.
REQ-004 The module SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The module SHALL have port flush, input, 1 bit: synchronous pipeline clear.
REQ-007 The module SHALL have port in_valid, input, 1 bit: upstream data valid.
REQ-008 The module SHALL have port in_data, input, WIDTH bits: upstream data.
REQ-009 The module SHALL have port in_ready, output, 1 bit: the pipe accepts in_data this cycle.
REQ-010 The module SHALL have port out_valid, output, 1 bit: the last stage holds valid data.
REQ-011 The module SHALL have port out_data, output, WIDTH bits: last-stage data register.
REQ-012 The module SHALL have port out_ready, input, 1 bit: downstream accepts this cycle.
REQ-013 The module SHALL have port occupancy, output, $clog2(DEPTH+1) bits: count of valid stages.

Function
REQ-014 The pipe SHALL hold DEPTH stages, each with one data register (WIDTH bits) and one valid bit; stage 0 is the input end and stage DEPTH-1 drives out_data and out_valid.
REQ-015 Stage readiness SHALL be rdy[DEPTH]=out_ready and rdy[k]=~v[k] | rdy[k+1], so bubbles collapse. The rdy path from out_ready to in_ready is combinational.
REQ-016 in_ready SHALL equal rdy[0] & ~flush & ~rst.
REQ-017 A transfer SHALL occur on a rising edge where in_valid & in_ready is high; a word leaves the pipe on an edge where out_valid & out_ready is high.
REQ-018 When rdy[k]=1, v[k] SHALL load the valid bit of the source (the in_valid & in_ready transfer for k=0, otherwise v[k-1]); when rdy[k]=0, stage k SHALL hold its valid bit and data.
REQ-019 A stage data register SHALL load only when rdy[k]=1 and the incoming valid is 1; otherwise it SHALL retain its value, including when the stage becomes empty.
REQ-020 With out_ready held at 1, a word accepted at edge t SHALL appear on out_data with out_valid=1 in the cycle after edge t+DEPTH-1, giving DEPTH cycles of latency.
REQ-021 Words SHALL exit in acceptance order, with no loss or duplication under any in_valid/out_ready pattern.
REQ-022 When full with out_ready=0, all stages SHALL hold and in_ready SHALL be 0.
REQ-023 When full with out_ready=1 and in_valid=1 in the same cycle, one word SHALL exit, one SHALL enter, and occupancy SHALL be unchanged.
REQ-024 out_data SHALL drive the stage DEPTH-1 data register whatever the state of out_valid.
REQ-025 occupancy SHALL be the combinational population count of v[DEPTH-1:0], ranging from 0 to DEPTH.
REQ-026 When flush=1 at an edge, the pipe SHALL clear all valid bits, load RST_VAL into all data registers, and accept no input.
REQ-027 Priority SHALL be rst > flush > normal operation.

Reset
REQ-028 When rst=1 at a rising edge of clk, all valid bits SHALL go to 0 and all data registers SHALL load RST_VAL.
REQ-029 After reset: out_valid=0, out_data=RST_VAL, occupancy=0; in_ready=1 from the first cycle with rst=0 and flush=0.
REQ-030 rst SHALL have no asynchronous effect; if rst is asserted mid-stream, in-flight words SHALL be discarded at the next edge.

Verification (WIDTH=8, DEPTH=3, RST_VAL=8'hA5)
REQ-031 Bench case: rst high for 2 edges, then low -> out_valid=0, out_data=8'hA5, occupancy=0, in_ready=1.
REQ-032 Bench case: out_ready=1, push 8'h01, 8'h02, 8'h03 on consecutive edges -> out_data=8'h01 with out_valid=1 in the cycle after the 3rd edge, then 02 and 03 on the following cycles.
REQ-033 Bench case: out_ready=0, push 4 words -> after 3 edges occupancy=3 and in_ready=0; the 4th word is held upstream. Raise out_ready -> words 1..4 exit in order, and in_ready=1 in the same cycle out_ready rises.
REQ-034 Bench case: full pipe with in_valid=1 and out_ready=1 for 5 edges -> occupancy stays 3 and the output sequence is contiguous.
REQ-035 Bench case: occupancy=2, then flush and in_valid both high for one edge -> the input is not accepted; next cycle occupancy=0, out_data=8'hA5, out_valid=0.
REQ-036 Bench case: push a word at the same edge rst is asserted -> the word is discarded and the post-reset state matches REQ-031.

Source files
------------

// File: rtl/c3lib_pipe_set_stall.sv
// c3lib_pipe_set_stall: DEPTH-stage register pipe with per-stage valid bits
// and a collapsing-bubble stall chain. Every data register resets or flushes
// to RST_VAL. out_data always shows the last stage register, even when that
// stage is empty.
//
// Handshake: a word moves across an interface on a rising edge where both
// valid and ready are high (in_valid & in_ready upstream, out_valid &
// out_ready downstream). in_ready depends combinationally on out_ready
// through the stage ready chain, and is never a function of in_valid.
module c3lib_pipe_set_stall #(
  parameter int               WIDTH   = 1,
  parameter int               DEPTH   = 2,
  parameter logic [WIDTH-1:0] RST_VAL = '1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [WIDTH-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] data_q [DEPTH];
  logic [DEPTH-1:0] v_q;
  logic [DEPTH:0]   rdy;
  logic [DEPTH-1:0] src_v;
  logic [WIDTH-1:0] src_d  [DEPTH];
  logic             push;

  // Ready chain: a stage can take a word when it is empty or is itself
  // draining forward, so empty stages never block the stages behind them.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = ~v_q[k] | rdy[k+1];
    end
  end

  assign in_ready = rdy[0] & ~flush & ~rst;
  assign push     = in_valid & in_ready;

  // Source of each stage: the upstream transfer for stage 0, otherwise the
  // previous stage.
  always_comb begin
    src_v    = '0;
    src_v[0] = push;
    src_d[0] = in_data;
    for (int k = 1; k < DEPTH; k++) begin
      src_v[k] = v_q[k-1];
      src_d[k] = data_q[k-1];
    end
  end

  // Stage registers: reset/flush clear valids and load RST_VAL; otherwise a
  // ready stage takes its source valid, and its data only when that is valid.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      v_q <= '0;
      for (int k = 0; k < DEPTH; k++) begin
        data_q[k] <= RST_VAL;
      end
    end else begin
      for (int k = 0; k < DEPTH; k++) begin
        if (rdy[k]) begin
          v_q[k] <= src_v[k];
          if (src_v[k]) begin
            data_q[k] <= src_d[k];
          end
        end
      end
    end
  end

  assign out_valid = v_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

  // Occupancy is the population count of the stage valid bits.
  always_comb begin
    occupancy = '0;
    for (int k = 0; k < DEPTH; k++) begin
      occupancy = occupancy + OCC_W'(v_q[k]);
    end
  end

endmodule

// File: tb/tb_c3lib_pipe_set_stall.sv
// Bench for c3lib_pipe_set_stall (WIDTH=8, DEPTH=3, RST_VAL=8'hA5).
// The reference model tracks the words in flight as a list of (stage
// position, data) pairs, oldest first, and derives every output from it.
module tb_c3lib_pipe_set_stall;

  localparam int         W  = 8;
  localparam int         D  = 3;
  localparam logic [7:0] RV = 8'hA5;

  logic         clk;
  logic         rst;
  logic         flush;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;
  logic [1:0]   occupancy;

  int checks = 0;
  int errors = 0;

  c3lib_pipe_set_stall #(.WIDTH(W), .DEPTH(D), .RST_VAL(RV)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .occupancy (occupancy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checker ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int         m_pos[$];
  logic [7:0] m_dat[$];
  logic [7:0] m_out;
  bit         m_live = 0;

  // True when the word at stage 0 (if any) vacates it at the coming edge.
  function automatic bit m_stage0_free();
    int prev;
    int np;
    int first;
    bit free;
    free  = 1'b1;
    prev  = D;
    first = (m_pos.size() > 0 && m_pos[0] == D - 1 && out_ready) ? 1 : 0;
    for (int i = first; i < m_pos.size(); i++) begin
      np   = (m_pos[i] + 1 < prev - 1) ? m_pos[i] + 1 : prev - 1;
      prev = np;
      if (m_pos[i] == 0 && np == 0) free = 1'b0;
    end
    return free;
  endfunction

  function automatic bit m_in_ready();
    return m_stage0_free() && !flush && !rst;
  endfunction

  function automatic bit m_out_valid();
    return m_pos.size() > 0 && m_pos[0] == D - 1;
  endfunction

  // Advance the model by one edge from the inputs that were stable before it.
  always @(posedge clk) begin
    if (rst || flush) begin
      m_pos.delete();
      m_dat.delete();
      m_out = RV;
      if (rst) m_live = 1'b1;
    end else if (m_live) begin
      bit push;
      int prev;
      int np;
      push = in_valid && m_in_ready();
      if (m_out_valid() && out_ready) begin
        void'(m_pos.pop_front());
        void'(m_dat.pop_front());
      end
      prev = D;
      for (int i = 0; i < m_pos.size(); i++) begin
        np       = (m_pos[i] + 1 < prev - 1) ? m_pos[i] + 1 : prev - 1;
        m_pos[i] = np;
        prev     = np;
      end
      if (push) begin
        m_pos.push_back(0);
        m_dat.push_back(in_data);
      end
      for (int i = 0; i < m_pos.size(); i++) begin
        if (m_pos[i] == D - 1) m_out = m_dat[i];
      end
    end
  end

  // ---------------- scoreboard: order of words leaving the pipe ----------------
  logic [W-1:0] exp_q[$];

  // Compare every output against the model on the falling edge.
  always @(negedge clk) begin
    if (m_live) begin
      chk("out_valid", 32'(out_valid), 32'(m_out_valid()));
      chk("occupancy", 32'(occupancy), 32'(m_pos.size()));
      chk("in_ready",  32'(in_ready),  32'(m_in_ready()));
      chk("out_data",  32'(out_data),  32'(m_out));
      if (rst || flush) begin
        exp_q.delete();
      end else begin
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            chk("sb_unexpected_word", 32'(out_data), 32'hFFFF_FFFF);
          end else begin
            chk("sb_order", 32'(out_data), 32'(exp_q.pop_front()));
          end
        end
        if (in_valid && m_in_ready()) exp_q.push_back(in_data);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic ordy);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"},  32'(out_data),  32'hA5);
    chk({tag, "_occupancy"}, 32'(occupancy), 32'd0);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    rst = 1'b1; flush = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    step(); step();
    rst = 1'b0;
    #1;
    chk_idle("reset");

    // Latency: three back-to-back words with out_ready high.
    drive(1'b1, 8'h01, 1'b1); step();
    drive(1'b1, 8'h02, 1'b1); step();
    drive(1'b1, 8'h03, 1'b1); step();
    drive(1'b0, 8'h00, 1'b1);
    chk("lat_v1", 32'(out_valid), 32'd1);
    chk("lat_d1", 32'(out_data),  32'h01);
    step(); chk("lat_d2", 32'(out_data), 32'h02);
    step(); chk("lat_d3", 32'(out_data), 32'h03);
    step(); chk("lat_empty", 32'(occupancy), 32'd0);

    // Stall: fill with out_ready low, fourth word waits upstream.
    drive(1'b1, 8'h11, 1'b0); step();
    drive(1'b1, 8'h12, 1'b0); step();
    drive(1'b1, 8'h13, 1'b0); step();
    chk("stall_occ",  32'(occupancy), 32'd3);
    chk("stall_rdy0", 32'(in_ready),  32'd0);
    drive(1'b1, 8'h14, 1'b0); step();
    chk("stall_hold_occ", 32'(occupancy), 32'd3);
    chk("stall_hold_d",   32'(out_data),  32'h11);
    out_ready = 1'b1;
    #1;
    chk("stall_rdy_comb", 32'(in_ready), 32'd1);
    step();
    drive(1'b0, 8'h00, 1'b1);
    chk("drain_d12", 32'(out_data), 32'h12);
    step(); chk("drain_d13", 32'(out_data), 32'h13);
    step(); chk("drain_d14", 32'(out_data), 32'h14);
    step(); chk("drain_empty", 32'(out_valid), 32'd0);

    // Full-rate streaming through a full pipe.
    drive(1'b1, 8'h21, 1'b0); step();
    drive(1'b1, 8'h22, 1'b0); step();
    drive(1'b1, 8'h23, 1'b0); step();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 8'(8'h24 + i), 1'b1);
      step();
      chk("stream_occ", 32'(occupancy), 32'd3);
      chk("stream_d",   32'(out_data),  32'(8'h22 + i));
    end
    drive(1'b0, 8'h00, 1'b1);
    step(); step(); step();
    chk("stream_empty", 32'(occupancy), 32'd0);

    // Flush with two words in flight and a word offered.
    drive(1'b1, 8'h31, 1'b0); step();
    drive(1'b1, 8'h32, 1'b0); step();
    drive(1'b0, 8'h00, 1'b0);
    chk("flush_pre_occ", 32'(occupancy), 32'd2);
    flush = 1'b1;
    drive(1'b1, 8'h33, 1'b0);
    #1;
    chk("flush_rdy", 32'(in_ready), 32'd0);
    step();
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    chk("flush_occ",  32'(occupancy), 32'd0);
    chk("flush_d",    32'(out_data),  32'hA5);
    chk("flush_v",    32'(out_valid), 32'd0);
    step(); step(); step();
    chk("flush_no_ghost", 32'(occupancy), 32'd0);

    // Reset asserted at the same edge a word is offered.
    drive(1'b1, 8'h40, 1'b0); step();
    rst = 1'b1;
    drive(1'b1, 8'h41, 1'b0);
    step();
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    #1;
    chk_idle("rst_mid");

    // Mixed traffic; the per-cycle model comparison covers every cycle.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      flush = ($urandom_range(0, 29) == 0);
      step();
    end
    flush = 1'b0;
    drive(1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) step();
    chk("final_sb_empty", 32'(exp_q.size()), 32'd0);
    chk("final_occ",      32'(occupancy),    32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
